// File: rtl/ultrasonido_distancia.sv
// ultrasonido_distancia
// Converts an ultrasonic echo-width count into a distance in centimetres and
// three BCD digits. A rising edge of `calculate` latches `count`. A restoring
// divider then produces count / TICKS_PER_CM. The quotient is clamped to MAX_CM
// and converted to BCD by double-dabble. The result is presented with a
// one-cycle `valid` strobe and held until the next result.
//
// Ports:
//   CLKOUT        in   clock, rising edge active
//   reset         in   asynchronous active-low reset
//   count         in   echo width, sampled on the start edge only
//   calculate     in   level; its rising edge (while idle) starts a conversion
//   dist_cm       out  clamped distance in cm (binary)
//   bcd           out  hundreds[11:8], tens[7:4], units[3:0] of dist_cm
//   out_of_range  out  quotient exceeded MAX_CM
//   valid         out  one-cycle strobe announcing a new result
//   busy          out  high from the start edge through the valid cycle
//
// Configuration macro: ULTRA_AVG4_EN. When it is defined, the output is a
// running average of the last four clamped results. This adds one cycle of
// latency.
module ultrasonido_distancia #(
  parameter int unsigned COUNT_W      = 16,
  parameter int unsigned TICKS_PER_CM = 58,
  parameter int unsigned MAX_CM       = 400
) (
  input  logic               CLKOUT,
  input  logic               reset,
  input  logic [COUNT_W-1:0] count,
  input  logic               calculate,
  output logic [9:0]         dist_cm,
  output logic [11:0]        bcd,
  output logic               out_of_range,
  output logic               valid,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(COUNT_W + 1);
  localparam int unsigned REM_W = COUNT_W + 1;
  localparam logic [REM_W-1:0]   DIVISOR = REM_W'(TICKS_PER_CM);
  localparam logic [COUNT_W-1:0] MAX_Q   = COUNT_W'(MAX_CM);
  localparam logic [9:0]         MAX_RES = 10'(MAX_CM);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DIV   = 3'd1,
    S_CLAMP = 3'd2,
    S_AVG   = 3'd3,
    S_BCD   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_r, state_next;
  logic               calculate_d_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [COUNT_W-1:0] quo_r;
  logic [REM_W-1:0]   rem_r;
  logic [9:0]         result_r;
  logic               oor_r;
  logic [21:0]        dd_r;

  logic               start_s;
  logic [REM_W-1:0]   rem_shift_s;
  logic [REM_W-1:0]   rem_next_s;
  logic               ge_s;
  logic [9:0]         clamp_s;
  logic               oor_s;
  logic [21:0]        dd_adj_s;
  logic [21:0]        dd_step_s;

`ifdef ULTRA_AVG4_EN
  // Three previous clamped results; the fourth history entry is result_r itself.
  logic [9:0]  hist0_r, hist1_r, hist2_r;
  logic [11:0] sum_s;
  logic [9:0]  avg_s;
`endif

  // Add 3 to a BCD digit of 5 or more, ahead of the double-dabble shift.
  function automatic logic [3:0] dab_adj(input logic [3:0] d);
    dab_adj = (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  // State register.
  always_ff @(posedge CLKOUT or negedge reset) begin
    if (!reset) state_r <= S_IDLE;
    else        state_r <= state_next;
  end

  // Next-state logic; the counter below restarts on every state change.
  always_comb begin
    state_next = state_r;
    start_s    = calculate && !calculate_d_r && (state_r == S_IDLE);
    case (state_r)
      S_IDLE:  if (start_s) state_next = S_DIV; else state_next = S_IDLE;
      S_DIV:   if (cnt_r == CNT_W'(COUNT_W - 1)) state_next = S_CLAMP; else state_next = S_DIV;
`ifdef ULTRA_AVG4_EN
      S_CLAMP: state_next = S_AVG;
`else
      S_CLAMP: state_next = S_BCD;
`endif
      S_AVG:   state_next = S_BCD;
      S_BCD:   if (cnt_r == CNT_W'(9)) state_next = S_DONE; else state_next = S_BCD;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // One restoring-division step. A 1 shifted out of the remainder's top bit
  // means the shifted value certainly exceeds the divisor.
  always_comb begin
    rem_shift_s = {rem_r[REM_W-2:0], quo_r[COUNT_W-1]};
    ge_s        = rem_r[REM_W-1] || (rem_shift_s >= DIVISOR);
    if (ge_s) rem_next_s = rem_shift_s - DIVISOR;
    else      rem_next_s = rem_shift_s;
  end

  // Clamp the quotient to the sensor range.
  always_comb begin
    if (quo_r > MAX_Q) begin
      clamp_s = MAX_RES;
      oor_s   = 1'b1;
    end else begin
      clamp_s = quo_r[9:0];
      oor_s   = 1'b0;
    end
  end

  // One double-dabble step: adjust the three BCD digits, then shift left.
  always_comb begin
    dd_adj_s  = {dab_adj(dd_r[21:18]), dab_adj(dd_r[17:14]), dab_adj(dd_r[13:10]), dd_r[9:0]};
    dd_step_s = dd_adj_s << 1;
  end

`ifdef ULTRA_AVG4_EN
  // Average of the current clamped result and the three before it.
  always_comb begin
    sum_s = 12'(result_r) + 12'(hist0_r) + 12'(hist1_r) + 12'(hist2_r);
    avg_s = 10'(sum_s >> 2);
  end

  // History shift register, advanced once per conversion.
  always_ff @(posedge CLKOUT or negedge reset) begin
    if (!reset) begin
      hist0_r <= 10'd0;
      hist1_r <= 10'd0;
      hist2_r <= 10'd0;
    end else if (state_r == S_AVG) begin
      hist2_r <= hist1_r;
      hist1_r <= hist0_r;
      hist0_r <= result_r;
    end
  end
`endif

  // Datapath and registered outputs.
  always_ff @(posedge CLKOUT or negedge reset) begin
    if (!reset) begin
      calculate_d_r <= 1'b0;
      cnt_r         <= '0;
      quo_r         <= '0;
      rem_r         <= '0;
      result_r      <= 10'd0;
      oor_r         <= 1'b0;
      dd_r          <= 22'd0;
      dist_cm       <= 10'd0;
      bcd           <= 12'd0;
      out_of_range  <= 1'b0;
      valid         <= 1'b0;
      busy          <= 1'b0;
    end else begin
      calculate_d_r <= calculate;
      valid         <= 1'b0;
      // Stays high through the DONE->IDLE edge so that busy covers the valid cycle.
      busy          <= (state_next != S_IDLE) || (state_r == S_DONE);
      cnt_r         <= (state_next != state_r) ? '0 : (cnt_r + CNT_W'(1));
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            quo_r <= count;
            rem_r <= '0;
          end
        end
        S_DIV: begin
          quo_r <= {quo_r[COUNT_W-2:0], ge_s};
          rem_r <= rem_next_s;
        end
        S_CLAMP: begin
          result_r <= clamp_s;
          oor_r    <= oor_s;
          dd_r     <= {12'd0, clamp_s};
        end
`ifdef ULTRA_AVG4_EN
        S_AVG: begin
          result_r <= avg_s;
          dd_r     <= {12'd0, avg_s};
        end
`endif
        S_BCD: dd_r <= dd_step_s;
        S_DONE: begin
          dist_cm      <= result_r;
          bcd          <= dd_r[21:10];
          out_of_range <= oor_r;
          valid        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonido_distancia.sv
module tb_ultrasonido_distancia;

  logic        clk;
  logic        reset;
  logic [15:0] count;
  logic        calculate;
  logic [9:0]  dist_cm;
  logic [11:0] bcd;
  logic        out_of_range;
  logic        valid;
  logic        busy;

`ifdef ULTRA_AVG4_EN
  localparam int LAT = 29;
`else
  localparam int LAT = 28;
`endif

  int n_vec = 0;
  int n_err = 0;
  int hist[$];

  typedef struct {
    logic [15:0] cnt;
    int          exp_dist;
    int          exp_bcd;
    int          exp_oor;
  } vec_t;

  vec_t tbl[8];

  ultrasonido_distancia dut (
    .CLKOUT(clk), .reset(reset), .count(count), .calculate(calculate),
    .dist_cm(dist_cm), .bcd(bcd), .out_of_range(out_of_range),
    .valid(valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int to_bcd(input int d);
    return (d / 100) * 256 + ((d / 10) % 10) * 16 + (d % 10);
  endfunction

  // Reference model: floor division, clamp, optional 4-sample average.
  task automatic model(input int c, output int d, output int b, output int o);
    int raw;
    raw = c / 58;
    o   = (raw > 400) ? 1 : 0;
    if (raw > 400) raw = 400;
`ifdef ULTRA_AVG4_EN
    begin
      int sum;
      hist.push_front(raw);
      if (hist.size() > 4) void'(hist.pop_back());
      sum = 0;
      foreach (hist[k]) sum += hist[k];
      d = sum / 4;
    end
`else
    d = raw;
`endif
    b = to_bcd(d);
  endtask

  task automatic start(input logic [15:0] c);
    @(negedge clk);
    count     = c;
    calculate = 1'b1;
  endtask

  // Waits for valid from the start edge, checks latency, result and strobe shape.
  task automatic collect(input int ed, input int eb, input int eo, input string tag);
    int lat;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (i == 0) check({tag, " busy_rise"}, int'(busy), 1);
      if (valid) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      check({tag, " valid_timeout"}, 0, 1);
    end else begin
      check({tag, " latency"}, lat, LAT);
      check({tag, " dist_cm"}, int'(dist_cm), ed);
      check({tag, " bcd"}, int'(bcd), eb);
      check({tag, " out_of_range"}, int'(out_of_range), eo);
      @(posedge clk); #1;
      check({tag, " valid_drop"}, int'(valid), 0);
      check({tag, " busy_fall"}, int'(busy), 0);
      check({tag, " dist_hold"}, int'(dist_cm), ed);
    end
    @(negedge clk);
    calculate = 1'b0;
  endtask

  task automatic run(input logic [15:0] c, input string tag);
    int d, b, o;
    model(int'(c), d, b, o);
    start(c);
    collect(d, b, o, tag);
  endtask

  initial begin
    int d, b, o, nvalid, got;
    tbl[0] = '{16'd5800,  100, 'h100, 0};
    tbl[1] = '{16'd57,    0,   'h000, 0};
    tbl[2] = '{16'd116,   2,   'h002, 0};
    tbl[3] = '{16'd65535, 400, 'h400, 1};
    tbl[4] = '{16'd23200, 400, 'h400, 0};
    tbl[5] = '{16'd23257, 400, 'h400, 0};
    tbl[6] = '{16'd23258, 400, 'h400, 1};
    tbl[7] = '{16'd22679, 391, 'h391, 0};

    reset     = 1'b0;
    count     = 16'd5800;
    calculate = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({dist_cm, bcd, out_of_range, valid, busy}), 0);

    // calculate already high when reset releases: the first edge starts a conversion.
    model(5800, d, b, o);
    @(negedge clk);
    reset = 1'b1;
    collect(d, b, o, "post_reset_start");

    for (int i = 0; i < 8; i++) begin
      model(int'(tbl[i].cnt), d, b, o);
`ifndef ULTRA_AVG4_EN
      d = tbl[i].exp_dist;
      b = tbl[i].exp_bcd;
      o = tbl[i].exp_oor;
`endif
      start(tbl[i].cnt);
      collect(d, b, o, $sformatf("table%0d", i));
    end

    for (int i = 0; i < 15; i++) begin
      run(16'($urandom_range(0, 65535)), $sformatf("rand%0d", i));
    end

    // Retrigger while busy: exactly one result, from the first count.
    model(5800, d, b, o);
    start(16'd5800);
    nvalid = 0;
    got    = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (valid) begin
        nvalid++;
        got = int'(dist_cm);
      end
      if (i == 5) calculate = 1'b0;
      if (i == 6) begin
        calculate = 1'b1;
        count     = 16'd116;
      end
    end
    check("retrigger_valid_count", nvalid, 1);
    check("retrigger_dist", got, d);
    @(negedge clk);
    calculate = 1'b0;

    // Reset abort 10 cycles into the division.
    start(16'd5800);
    repeat (11) @(posedge clk);
    #1;
    reset     = 1'b0;
    calculate = 1'b0;
    hist.delete();
    #1;
    check("abort_outputs", int'({dist_cm, bcd, out_of_range, valid, busy}), 0);
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    check("abort_no_valid", nvalid, 0);
    run(16'd2900, "after_abort");

`ifdef ULTRA_AVG4_EN
    @(negedge clk);
    reset = 1'b0;
    hist.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int exp_avg[4];
      exp_avg = '{25, 75, 150, 250};
      model(5800 * (i + 1), d, b, o);
      start(16'(5800 * (i + 1)));
      collect(exp_avg[i], to_bcd(exp_avg[i]), 0, $sformatf("avg%0d", i));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ultrasonido_distancia.md
# ultrasonido_distancia

Converts the echo-width count produced by the ultrasonic echo counter into a distance in centimetres and three BCD digits for the display path. It sits directly downstream of the counter: it starts on the rising edge of the counter's `calculate` level, divides the captured count by a fixed ticks-per-centimetre constant, clamps the result to the sensor range and converts it to BCD. It presents a one-cycle `valid` strobe with outputs held until the next result.

## Interface
- `COUNT_W`, 16, width of the incoming echo count.
- `TICKS_PER_CM`, 58, count ticks per centimetre (58 at a 1 MHz count clock), must be ≥1.
- `MAX_CM`, 400, clamp limit in cm, must be ≤999.
- `CLKOUT`  in  1  single clock, rising edge active.
- `reset`  in  1  asynchronous, active-low reset.
- `count`  in  COUNT_W  echo width from the counter, sampled only at start.
- `calculate`  in  1  level from the counter; its rising edge requests a conversion.
- `dist_cm`  out  10  clamped distance in cm, binary.
- `bcd`  out  12  hundreds[11:8], tens[7:4], units[3:0] of `dist_cm`.
- `out_of_range`  out  1  set when the quotient exceeded `MAX_CM`.
- `valid`  out  1  one-cycle strobe: new result on `dist_cm`/`bcd`/`out_of_range`.
- `busy`  out  1  high from start until the cycle `valid` is asserted, inclusive.

## Operation
- Reset (`reset`=0): state IDLE; `dist_cm`=0, `bcd`=0, `out_of_range`=0, `valid`=0, `busy`=0; the edge-detect register `calculate_d` is 0. This means `calculate` high at the first clock after reset counts as a rising edge.
- Start condition: `calculate`=1, `calculate_d`=0, and state is IDLE. On that edge (E0), `count` is latched and the state goes to DIV.
- A rising edge of `calculate` while not IDLE is ignored and never queued.
- DIV: restoring shift-subtract division, one quotient bit per cycle, COUNT_W cycles. Produces quotient = floor(count/TICKS_PER_CM); the remainder is discarded.
- CLAMP (1 cycle): if quotient > MAX_CM, the result is MAX_CM with the out_of_range flag set. Otherwise the result is the quotient with the flag cleared. Quotient 0 is a legal in-range result.
- BCD (10 cycles): double-dabble on the 10-bit result, using add-3 on any digit ≥5 before each shift.
- DONE (1 cycle): `dist_cm`, `bcd` and `out_of_range` update, `valid`=1, `busy`=1. The next state is IDLE.
- Outputs hold their value between `valid` strobes.
- `busy` is 0 only in IDLE.
- Arithmetic: the divider remainder register is COUNT_W+1 bits wide. All intermediates are unsigned with no overflow, since the clamp precedes the 10-bit truncation.

## Timing
- `valid` rises COUNT_W+12 rising edges after E0 (28 for COUNT_W=16) and stays high exactly one cycle.
- `busy` rises in the cycle after E0 and falls in the cycle after `valid`.
- The earliest accepted restart is an edge sampled while in IDLE, the cycle after DONE. `calculate` must first have been sampled low.
- An asynchronous reset mid-operation aborts immediately: all outputs return to their reset values, and no `valid` is produced for the aborted conversion.

## Configuration
- `ULTRA_AVG4_EN` defined:
  - An AVG state follows CLAMP: the output is floor((sum of the last 4 clamped results)/4), using a 4-entry history cleared to 0 on reset.
  - The first three results after reset therefore average with zeros.
  - `out_of_range` reflects the current sample only.
  - Latency becomes COUNT_W+13.
- `ULTRA_AVG4_EN` undefined: no history registers exist and the raw clamped result is output.

## Test plan
- Basic conversion: `count`=5800, `calculate` 0→1 → `valid` 28 edges later; `dist_cm`=100, `bcd`=0x100, `out_of_range`=0.
- Truncation and zero: `count`=57 → `dist_cm`=0, `bcd`=0x000, `out_of_range`=0; then `count`=116 → 2, `bcd`=0x002.
- Clamp: `count`=65535 → quotient 1129, clamped: `dist_cm`=400, `bcd`=0x400, `out_of_range`=1.
- Busy retrigger: drop `calculate` and raise it again 5 cycles after start with `count` changed → exactly one `valid`, carrying the first count's result.
- Reset abort: assert `reset` 10 cycles into DIV → outputs 0, no `valid`. Then release reset and start with `count`=2900 → `dist_cm`=50.
- With `ULTRA_AVG4_EN`: counts for 100, 200, 300, 400 cm in sequence → `dist_cm` 25, 75, 150, 250, each `valid` at 29 edges.
